lcd_bus_responder: RTL and testbench
====================================

// Module: lcd_bus_responder
// PURPOSE
// - HD44780-style display-side model for the 8-bit LCD bus (rs, rw, en, lcd[7:0]) driven by the Qsys LCD controller.
// - Latches each bus cycle on the falling edge of en, decodes instructions and data, and keeps a 2x16 DDRAM image.
// - Emulates the busy flag and answers read cycles. Used as the bus partner in simulation and for on-board loopback checks.
// PARAMETERS
// - SYNC_STAGES        2      flops on en/rs/rw/lcd_din before edge detection (min 2)
// - BUSY_CYCLES        2000   busy duration after a normal instruction or data write (40 us at 50 MHz)
// - BUSY_CLEAR_CYCLES  82000  busy duration after Clear Display or Return Home (1.64 ms)
// PORTS
// - clk            in   1  system clock; the only clock
// - reset          in   1  synchronous, active-high reset
// - lcd_rs         in   1  register select: 0 = instruction, 1 = data
// - lcd_rw         in   1  0 = write, 1 = read
// - lcd_en         in   1  enable strobe; fields are latched on its falling edge
// - lcd_din        in   8  bus data from the controller
// - lcd_dout       out  8  read data returned to the controller
// - lcd_oe         out  1  high while lcd_dout is driven
// - busy           out  1  emulated busy flag (BF)
// - cursor_addr    out  7  address counter (AC)
// - disp_on        out  1  D bit
// - cursor_on      out  1  C bit
// - blink_on       out  1  B bit
// - cmd_valid      out  1  1-cycle pulse per accepted bus write
// - cmd_is_data    out  1  qualifies cmd_valid: 1 = data write, 0 = instruction
// - cmd_byte       out  8  byte accepted with cmd_valid
// - err_busy_wr    out  1  sticky: a write arrived while busy; cleared only by reset
// - rd_index       in   5  host readback index {line, col[3:0]}
// - rd_char        out  8  DDRAM[rd_index], combinational
// BEHAVIOUR
// - Reset values: DDRAM all 0x20, AC=0, I/D=1, S=0, D=C=B=0, busy=0, lcd_oe=0, lcd_dout=0, cmd_valid=0, err_busy_wr=0, busy counter=0.
// - Reset has priority over every other event, including an in-progress busy period or an active read cycle.
// - Inputs are synchronised through SYNC_STAGES flops. Falling edge = synced en was 1 last cycle and is 0 now.
// - rs, rw and din are taken from the same synced stage as the edge.
// - Write cycle (rw=0), on the falling edge:
//   - If busy: drop the byte, set err_busy_wr, no cmd_valid, no state change.
//   - Else: act on the byte and pulse cmd_valid on the next cycle.
// - Instruction decode (rs=0), highest set bit wins:
//   - 1xxxxxxx Set DDRAM Addr: AC = din[6:0].
//   - 01xxxxxx Set CGRAM: accepted, no effect.
//   - 001xxxxx Function Set: accepted, no effect; the model is 8-bit only.
//   - 0001xxxx Shift: accepted, no effect.
//   - 00001DCB Display Control: load D, C, B.
//   - 000001IS Entry Mode: load I/D and S. S is stored, shift not modelled.
//   - 00000010 Return Home: AC = 0, long busy.
//   - 00000001 Clear Display: all 32 cells = 0x20, AC = 0, I/D = 1, long busy.
//   - 0x00: ignored, no busy, cmd_valid still pulses.
// - Data write (rs=1): DDRAM[{AC[6],AC[3:0]}] = din, then AC steps. AC[5:4] are ignored for indexing.
// - AC step:
//   - I/D=1: 0x0F->0x40, 0x4F->0x00, otherwise +1.
//   - I/D=0: 0x00->0x4F, 0x40->0x0F, otherwise -1.
//   - Any other AC value steps by +/-1 modulo 128.
// - Busy: the counter loads BUSY_CYCLES or BUSY_CLEAR_CYCLES in the cycle the write is accepted. busy=1 from the next cycle.
// - The counter decrements each cycle. busy drops the cycle it reaches 0.
// - Read cycle (rw=1):
//   - lcd_oe=1 from the first cycle synced en=1 until the cycle after synced en falls.
//   - rs=0: lcd_dout = {busy, AC}. Allowed while busy, never an error.
//   - rs=1: lcd_dout = DDRAM[{AC[6],AC[3:0]}]. On the falling edge AC steps, but only when not busy.
// - rw changing while en=1: the value at the falling edge defines the cycle.
// - en toggling faster than the sync depth is unsupported. No recovery is required.
// STRUCTURE
// - Shared package lcd_defs: opcode masks, the space code 0x20, line base addresses 0x00/0x40, the index-mapping function.
// - Sub-module lcd_ddram: 32x8 register array with write port, synchronous clear-all and combinational read ports.
// - The top module holds the synchroniser, edge detector, decoder, AC, busy counter and read mux.
// TESTING
// - Bench overrides: BUSY_CYCLES=4, BUSY_CLEAR_CYCLES=10.
// 1. Reset, then rd_index 0..31 -> every rd_char=0x20, busy=0, cursor_addr=0.
// 2. Write 0x0F -> disp_on=cursor_on=blink_on=1, cmd_valid for 1 cycle, busy high for 4 cycles.
// 3. Write 0x8E, then data 0x41, 0x42, 0x43 (each after busy drops) -> cells 14,15,16 = A,B,C; cursor_addr=0x41.
// 4. Write 0x06, then data 0x58 immediately with no busy wait -> 0x58 dropped, err_busy_wr=1, cells unchanged.
// 5. Write 0x01, then read with rs=0 during busy -> lcd_dout=0x80. After 10 cycles busy=0 and all cells read 0x20.
// 6. Write 0x04 and 0x80, then data 0x5A -> cell 0 = 0x5A, cursor_addr=0x4F. Assert reset mid-busy -> busy=0 and cell 0=0x20 next cycle.

Source files
------------

// File: rtl/lcd_bus_responder_pkg.sv
// Shared definitions for the LCD bus responder: character codes, line bases,
// instruction classes and the address-counter helpers.
package lcd_defs;

    localparam logic [7:0] SPACE_CHAR = 8'h20;
    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LAST_COL   = 7'h0F;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_CLEAR,
        OP_HOME,
        OP_ENTRY,
        OP_DISPLAY,
        OP_SHIFT,
        OP_FUNC,
        OP_CGRAM,
        OP_DDRAM
    } op_e;

    // The highest set bit selects the instruction class.
    function automatic op_e decode_op(input logic [7:0] b);
        if (b[7])      return OP_DDRAM;
        else if (b[6]) return OP_CGRAM;
        else if (b[5]) return OP_FUNC;
        else if (b[4]) return OP_SHIFT;
        else if (b[3]) return OP_DISPLAY;
        else if (b[2]) return OP_ENTRY;
        else if (b[1]) return OP_HOME;
        else if (b[0]) return OP_CLEAR;
        else           return OP_NONE;
    endfunction

    // Only AC[6] (line) and AC[3:0] (column) select a cell.
    function automatic logic [4:0] ddram_index(input logic [6:0] ac);
        return {ac[6], ac[3:0]};
    endfunction

    // Visible columns wrap between the two lines; other addresses count mod 128.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == (LINE0_BASE | LAST_COL)) return LINE1_BASE;
            if (ac == (LINE1_BASE | LAST_COL)) return LINE0_BASE;
            return ac + 7'd1;
        end else begin
            if (ac == LINE0_BASE) return LINE1_BASE | LAST_COL;
            if (ac == LINE1_BASE) return LINE0_BASE | LAST_COL;
            return ac - 7'd1;
        end
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 2x16 display data RAM image: one write port, a clear-all, two combinational
// read ports (bus read mux and host readback).
module lcd_ddram
    import lcd_defs::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic [4:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [4:0] raddr_b,
    output logic [7:0] rdata_b
);

    logic [7:0] mem [32];

    // NOTE: every cell is cleared here on purpose -- blanking the whole screen
    // in one cycle is visible behaviour, so this stays a register array
    // rather than a RAM that would only be written one word at a time.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= SPACE_CHAR;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style display-side responder for the 8-bit LCD bus: latches bus
// cycles on the falling edge of en, keeps a 2x16 DDRAM image and a busy flag.
module lcd_bus_responder
    import lcd_defs::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int BUSY_CYCLES       = 2000,
    parameter int BUSY_CLEAR_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_din,
    output logic [7:0] lcd_dout,
    output logic       lcd_oe,
    output logic       busy,
    output logic [6:0] cursor_addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       cmd_valid,
    output logic       cmd_is_data,
    output logic [7:0] cmd_byte,
    output logic       err_busy_wr,
    input  logic [4:0] rd_index,
    output logic [7:0] rd_char
);

    localparam int CNT_W = $clog2(BUSY_CLEAR_CYCLES + 1);

    // en, rs, rw and din travel together so all fields come from one stage.
    logic [10:0] sync_q [SYNC_STAGES];
    logic        en_s, rs_s, rw_s, en_d;
    logic [7:0]  din_s;

    // NOTE: non-blocking assignments make each stage take the previous
    // stage's old value, which is what turns this loop into a shift chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            en_d <= 1'b0;
        end else begin
            sync_q[0] <= {lcd_en, lcd_rs, lcd_rw, lcd_din};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            en_d <= en_s;
        end
    end

    assign {en_s, rs_s, rw_s, din_s} = sync_q[SYNC_STAGES-1];

    logic fall, wr_fall, rd_fall, accept;
    op_e  op;

    assign fall    = en_d & ~en_s;
    assign wr_fall = fall & ~rw_s;
    assign rd_fall = fall & rw_s;
    assign accept  = wr_fall & ~busy;
    assign op      = decode_op(din_s);

    logic [6:0]     ac_q, ac_n;
    logic           id_q, id_n, s_q, s_n;
    logic           d_q, d_n, c_q, c_n, b_q, b_n;
    logic           mem_we, clear_cmd;
    logic           cnt_load;
    logic [CNT_W-1:0] cnt_q, cnt_val;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        ac_n      = ac_q;
        id_n      = id_q;
        s_n       = s_q;
        d_n       = d_q;
        c_n       = c_q;
        b_n       = b_q;
        mem_we    = 1'b0;
        clear_cmd = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = CNT_W'(BUSY_CYCLES);

        if (accept) begin
            cnt_load = 1'b1;
            if (rs_s) begin
                mem_we = 1'b1;
                ac_n   = ac_step(ac_q, id_q);
            end else begin
                unique case (op)
                    OP_DDRAM:   ac_n = din_s[6:0];
                    OP_DISPLAY: {d_n, c_n, b_n} = din_s[2:0];
                    OP_ENTRY:   {id_n, s_n} = din_s[1:0];
                    OP_HOME: begin
                        ac_n    = LINE0_BASE;
                        cnt_val = CNT_W'(BUSY_CLEAR_CYCLES);
                    end
                    OP_CLEAR: begin
                        clear_cmd = 1'b1;
                        ac_n      = LINE0_BASE;
                        id_n      = 1'b1;
                        cnt_val   = CNT_W'(BUSY_CLEAR_CYCLES);
                    end
                    OP_NONE:    cnt_load = 1'b0;
                    default:    ;
                endcase
            end
        end else if (rd_fall && rs_s && !busy) begin
            ac_n = ac_step(ac_q, id_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ac_q        <= LINE0_BASE;
            id_q        <= 1'b1;
            s_q         <= 1'b0;
            d_q         <= 1'b0;
            c_q         <= 1'b0;
            b_q         <= 1'b0;
            cnt_q       <= '0;
            cmd_valid   <= 1'b0;
            cmd_is_data <= 1'b0;
            cmd_byte    <= 8'h00;
            err_busy_wr <= 1'b0;
        end else begin
            ac_q      <= ac_n;
            id_q      <= id_n;
            s_q       <= s_n;
            d_q       <= d_n;
            c_q       <= c_n;
            b_q       <= b_n;
            cmd_valid <= accept;
            if (accept) begin
                cmd_is_data <= rs_s;
                cmd_byte    <= din_s;
            end
            if (cnt_load)          cnt_q <= cnt_val;
            else if (cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
            if (wr_fall && busy)   err_busy_wr <= 1'b1;
        end
    end

    assign busy        = (cnt_q != '0);
    assign cursor_addr = ac_q;
    assign disp_on     = d_q;
    assign cursor_on   = c_q;
    assign blink_on    = b_q;

    logic [7:0] ram_rd;

    lcd_ddram u_ddram (
        .clk     (clk),
        .clr     (reset | clear_cmd),
        .we      (mem_we),
        .waddr   (ddram_index(ac_q)),
        .wdata   (din_s),
        .raddr_a (ddram_index(ac_q)),
        .rdata_a (ram_rd),
        .raddr_b (rd_index),
        .rdata_b (rd_char)
    );

    // Drive the bus through the whole read strobe plus the cycle en falls.
    assign lcd_oe   = rw_s & (en_s | en_d);
    assign lcd_dout = !lcd_oe ? 8'h00 : (rs_s ? ram_rd : {busy, ac_q});

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder with a scoreboard of accepted writes.
module tb_lcd_bus_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0] lcd_din = 8'h00;
    logic [7:0] lcd_dout;
    logic       lcd_oe, busy, disp_on, cursor_on, blink_on;
    logic       cmd_valid, cmd_is_data, err_busy_wr;
    logic [6:0] cursor_addr;
    logic [7:0] cmd_byte, rd_char;
    logic [4:0] rd_index = 5'd0;

    int checks = 0;
    int errors = 0;
    int busy_cycles = 0;
    int cv_count = 0;
    logic [8:0] exp_q [$];

    lcd_bus_responder #(
        .SYNC_STAGES       (2),
        .BUSY_CYCLES       (4),
        .BUSY_CLEAR_CYCLES (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_en      (lcd_en),
        .lcd_din     (lcd_din),
        .lcd_dout    (lcd_dout),
        .lcd_oe      (lcd_oe),
        .busy        (busy),
        .cursor_addr (cursor_addr),
        .disp_on     (disp_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .cmd_valid   (cmd_valid),
        .cmd_is_data (cmd_is_data),
        .cmd_byte    (cmd_byte),
        .err_busy_wr (err_busy_wr),
        .rd_index    (rd_index),
        .rd_char     (rd_char)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer and activity counters, sampled away from posedge.
    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (!reset && cmd_valid) begin
            cv_count++;
            check("cmd_q_nonempty", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) check("cmd_word", {cmd_is_data, cmd_byte}, exp_q.pop_front());
        end
    end

    // Caller is at a negedge; returns at a negedge, before the edge is seen.
    task automatic bus_write(input logic rs, input logic [7:0] d, input logic expect_accept);
        if (expect_accept) exp_q.push_back({rs, d});
        lcd_rs = rs; lcd_rw = 1'b0; lcd_din = d; lcd_en = 1'b1;
        repeat (2) @(negedge clk);
        lcd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] data, output logic oe);
        lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        data = lcd_dout;
        oe = lcd_oe;
        lcd_en = 1'b0;
        repeat (3) @(negedge clk);
        lcd_rw = 1'b0;
    endtask

    task automatic wait_not_busy();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("busy_drop", busy, 1'b0);
    endtask

    task automatic check_cell(input string tag, input int idx, input logic [7:0] exp);
        rd_index = 5'(idx);
        #1;
        check(tag, rd_char, exp);
    endtask

    logic [7:0] rdata;
    logic       roe;
    int         snap_busy, snap_cv;

    initial begin
        // 1. Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) check_cell("reset_cell", i, 8'h20);
        check("reset_busy", busy, 1'b0);
        check("reset_ac", cursor_addr, 7'h00);
        check("reset_oe", lcd_oe, 1'b0);
        check("reset_dout", lcd_dout, 8'h00);
        check("reset_dcb", {disp_on, cursor_on, blink_on}, 3'b000);
        check("reset_err", err_busy_wr, 1'b0);

        // 2. Display control
        snap_busy = busy_cycles; snap_cv = cv_count;
        bus_write(1'b0, 8'h0F, 1'b1);
        wait_not_busy();
        check("dcb_on", {disp_on, cursor_on, blink_on}, 3'b111);
        check("dcb_cmd_pulses", 16'(cv_count - snap_cv), 16'd1);
        check("dcb_busy_len", 16'(busy_cycles - snap_busy), 16'd4);

        // 3. Set address 0x0E and write across the line-0 to line-1 wrap
        bus_write(1'b0, 8'h8E, 1'b1); wait_not_busy();
        bus_write(1'b1, 8'h41, 1'b1); wait_not_busy();
        bus_write(1'b1, 8'h42, 1'b1); wait_not_busy();
        bus_write(1'b1, 8'h43, 1'b1); wait_not_busy();
        check_cell("cell14", 14, 8'h41);
        check_cell("cell15", 15, 8'h42);
        check_cell("cell16", 16, 8'h43);
        check("ac_wrap", cursor_addr, 7'h41);
        check("err_still_clear", err_busy_wr, 1'b0);

        // 4. Data write while busy is dropped
        bus_write(1'b0, 8'h06, 1'b1);
        bus_write(1'b1, 8'h58, 1'b0);
        wait_not_busy();
        check("err_busy_wr", err_busy_wr, 1'b1);
        check_cell("cell17_kept", 17, 8'h20);
        check("ac_kept", cursor_addr, 7'h41);

        // 5. Clear display with a status read during the long busy
        snap_busy = busy_cycles;
        bus_write(1'b0, 8'h01, 1'b1);
        bus_read(1'b0, rdata, roe);
        check("status_oe", roe, 1'b1);
        check("status_dout", rdata, 8'h80);
        wait_not_busy();
        check("clear_busy_len", 16'(busy_cycles - snap_busy), 16'd10);
        check("clear_ac", cursor_addr, 7'h00);
        for (int i = 0; i < 32; i++) check_cell("clear_cell", i, 8'h20);
        check("idle_oe", lcd_oe, 1'b0);

        // 6. Decrement mode from 0x00 wraps to 0x4F; reset mid-busy
        bus_write(1'b0, 8'h04, 1'b1); wait_not_busy();
        bus_write(1'b0, 8'h80, 1'b1); wait_not_busy();
        bus_write(1'b1, 8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        check_cell("cell0_data", 0, 8'h5A);
        check("ac_dec_wrap", cursor_addr, 7'h4F);
        reset = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check_cell("rst_cell0", 0, 8'h20);
        check("rst_ac", cursor_addr, 7'h00);
        check("rst_err", err_busy_wr, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("cmd_q_drained", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
